// File: rtl/cube_tile_scheduler_if.sv
// Handshake/config bundle between the cube tile scheduler and its controller / cube-transfer wrapper.
interface cube_tile_scheduler_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CUBE_WIDTH = 6
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] fm_src_addr;
    logic [ADDR_WIDTH-1:0] fm_dst_addr;
    logic [CUBE_WIDTH-1:0] fm_channel;
    logic [CUBE_WIDTH-1:0] fm_row;
    logic [CUBE_WIDTH-1:0] fm_col;
    logic [CUBE_WIDTH-1:0] tile_channel;
    logic [CUBE_WIDTH-1:0] tile_row;
    logic [CUBE_WIDTH-1:0] tile_col;
    logic [ADDR_WIDTH-1:0] src_base_addr;
    logic [ADDR_WIDTH-1:0] dst_base_addr;
    logic [CUBE_WIDTH-1:0] channel;
    logic [CUBE_WIDTH-1:0] row;
    logic [CUBE_WIDTH-1:0] col;
    logic [CUBE_WIDTH-1:0] channel_offset;
    logic [CUBE_WIDTH-1:0] row_offset;
    logic                  transfer_start;
    logic                  transfer_done;
    logic                  busy;
    logic                  done;
    logic                  config_err;
    logic [31:0]           busy_cycles;

    modport master (
        output start, fm_src_addr, fm_dst_addr, fm_channel, fm_row, fm_col,
               tile_channel, tile_row, tile_col, transfer_done,
        input  src_base_addr, dst_base_addr, channel, row, col, channel_offset,
               row_offset, transfer_start, busy, done, config_err, busy_cycles
    );

    modport slave (
        input  start, fm_src_addr, fm_dst_addr, fm_channel, fm_row, fm_col,
               tile_channel, tile_row, tile_col, transfer_done,
        output src_base_addr, dst_base_addr, channel, row, col, channel_offset,
               row_offset, transfer_start, busy, done, config_err, busy_cycles
    );
endinterface

// File: rtl/cube_tile_scheduler.sv
// Walks a feature map tile by tile (col fastest, then row, then channel) and issues one cube-transfer per tile.
// Optional busy-cycle counter compiled in with `define CUBE_TILE_SCHED_PERF_EN.
module cube_tile_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CUBE_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    cube_tile_scheduler_if.slave bus
);
    localparam int CW    = CUBE_WIDTH;
    localparam int OFFW  = 2 * CUBE_WIDTH;
    localparam int IW    = 3 * CUBE_WIDTH + 2;
    localparam int OW    = IW + 32;
    localparam int BYTES = DATA_WIDTH / 8;

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_WAIT, S_NEXT, S_FIN} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] fmSrcAddr_q, fmDstAddr_q;
    logic [CW-1:0]         fmChannel_q, fmRow_q, fmCol_q;
    logic [CW-1:0]         tileChannel_q, tileRow_q, tileCol_q;
    logic                  zeroDim_q;
    logic [CW-1:0]         c0_q, r0_q, k0_q;
    logic [IW-1:0]         dstAcc_q;
    logic [ADDR_WIDTH-1:0] srcBase_q, dstBase_q;
    logic [CW-1:0]         channel_q, row_q, col_q, channelOffset_q, rowOffset_q;
    logic                  transferStart_q, busy_q, done_q, configErr_q;

    logic [CW-1:0]         remChannel, remRow, remCol;
    logic [CW-1:0]         channel_d, row_d, col_d, rowOffset_d;
    logic [OFFW-1:0]       channelOffsetFull;
    logic                  offsetErr;
    logic [IW-1:0]         srcWords, tileWords;
    logic [ADDR_WIDTH-1:0] srcBase_d, dstBase_d;
    logic [CW:0]           kSum, rSum, cSum;
    logic                  colWrap, rowWrap, lastTile;

    // Command values for the current tile, plus where the indices go after it.
    always_comb begin
        remChannel        = fmChannel_q - c0_q;
        remRow            = fmRow_q - r0_q;
        remCol            = fmCol_q - k0_q;
        channel_d         = (tileChannel_q < remChannel) ? tileChannel_q : remChannel;
        row_d             = (tileRow_q < remRow) ? tileRow_q : remRow;
        col_d             = (tileCol_q < remCol) ? tileCol_q : remCol;
        rowOffset_d       = fmCol_q - col_d;
        channelOffsetFull = OFFW'(fmRow_q - row_d) * OFFW'(fmCol_q);
        offsetErr         = |channelOffsetFull[OFFW-1:CW];
        srcWords          = (IW'(c0_q) * IW'(fmRow_q) + IW'(r0_q)) * IW'(fmCol_q) + IW'(k0_q);
        srcBase_d         = fmSrcAddr_q + ADDR_WIDTH'(OW'(srcWords) * OW'($unsigned(BYTES)));
        dstBase_d         = fmDstAddr_q + ADDR_WIDTH'(OW'(dstAcc_q) * OW'($unsigned(BYTES)));
        tileWords         = IW'(channel_q) * IW'(row_q) * IW'(col_q);
        kSum              = {1'b0, k0_q} + {1'b0, tileCol_q};
        rSum              = {1'b0, r0_q} + {1'b0, tileRow_q};
        cSum              = {1'b0, c0_q} + {1'b0, tileChannel_q};
        colWrap           = kSum >= {1'b0, fmCol_q};
        rowWrap           = rSum >= {1'b0, fmRow_q};
        lastTile          = colWrap && rowWrap && (cSum >= {1'b0, fmChannel_q});
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            fmSrcAddr_q     <= '0;
            fmDstAddr_q     <= '0;
            fmChannel_q     <= '0;
            fmRow_q         <= '0;
            fmCol_q         <= '0;
            tileChannel_q   <= '0;
            tileRow_q       <= '0;
            tileCol_q       <= '0;
            zeroDim_q       <= 1'b0;
            c0_q            <= '0;
            r0_q            <= '0;
            k0_q            <= '0;
            dstAcc_q        <= '0;
            srcBase_q       <= '0;
            dstBase_q       <= '0;
            channel_q       <= '0;
            row_q           <= '0;
            col_q           <= '0;
            channelOffset_q <= '0;
            rowOffset_q     <= '0;
            transferStart_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            configErr_q     <= 1'b0;
        end else begin
            transferStart_q <= 1'b0;
            done_q          <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        fmSrcAddr_q   <= bus.fm_src_addr;
                        fmDstAddr_q   <= bus.fm_dst_addr;
                        fmChannel_q   <= bus.fm_channel;
                        fmRow_q       <= bus.fm_row;
                        fmCol_q       <= bus.fm_col;
                        tileChannel_q <= bus.tile_channel;
                        tileRow_q     <= bus.tile_row;
                        tileCol_q     <= bus.tile_col;
                        zeroDim_q     <= (bus.fm_channel == '0) || (bus.fm_row == '0) ||
                                         (bus.fm_col == '0) || (bus.tile_channel == '0) ||
                                         (bus.tile_row == '0) || (bus.tile_col == '0);
                        configErr_q   <= (bus.fm_channel == '0) || (bus.fm_row == '0) ||
                                         (bus.fm_col == '0) || (bus.tile_channel == '0) ||
                                         (bus.tile_row == '0) || (bus.tile_col == '0);
                        c0_q          <= '0;
                        r0_q          <= '0;
                        k0_q          <= '0;
                        dstAcc_q      <= '0;
                        busy_q        <= 1'b1;
                        state_q       <= S_CALC;
                    end
                end
                // A bad configuration still passes through CALC so done lands two cycles after start.
                S_CALC: begin
                    if (zeroDim_q || offsetErr) begin
                        configErr_q <= 1'b1;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_FIN;
                    end else begin
                        srcBase_q       <= srcBase_d;
                        dstBase_q       <= dstBase_d;
                        channel_q       <= channel_d;
                        row_q           <= row_d;
                        col_q           <= col_d;
                        rowOffset_q     <= rowOffset_d;
                        channelOffset_q <= channelOffsetFull[CW-1:0];
                        transferStart_q <= 1'b1;
                        state_q         <= S_ISSUE;
                    end
                end
                S_ISSUE: state_q <= S_WAIT;
                S_WAIT: begin
                    if (bus.transfer_done) state_q <= S_NEXT;
                end
                S_NEXT: begin
                    dstAcc_q <= dstAcc_q + tileWords;
                    if (lastTile) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        state_q <= S_CALC;
                        if (!colWrap) begin
                            k0_q <= kSum[CW-1:0];
                        end else begin
                            k0_q <= '0;
                            if (!rowWrap) begin
                                r0_q <= rSum[CW-1:0];
                            end else begin
                                r0_q <= '0;
                                c0_q <= cSum[CW-1:0];
                            end
                        end
                    end
                end
                S_FIN:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef CUBE_TILE_SCHED_PERF_EN
    logic [31:0] busyCycles_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            busyCycles_q <= '0;
        end else if (state_q == S_IDLE && bus.start) begin
            busyCycles_q <= '0;
        end else if (busy_q && busyCycles_q != '1) begin
            busyCycles_q <= busyCycles_q + 32'd1;
        end
    end

    assign bus.busy_cycles = busyCycles_q;
`else
    assign bus.busy_cycles = '0;
`endif

    assign bus.src_base_addr  = srcBase_q;
    assign bus.dst_base_addr  = dstBase_q;
    assign bus.channel        = channel_q;
    assign bus.row            = row_q;
    assign bus.col            = col_q;
    assign bus.channel_offset = channelOffset_q;
    assign bus.row_offset     = rowOffset_q;
    assign bus.transfer_start = transferStart_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.config_err     = configErr_q;
endmodule

// File: doc/cube_tile_scheduler.md
# cube_tile_scheduler

Upstream control stage for the CDMA cube-transfer wrapper. Partitions a large feature map in DDR into 3-D tiles (channel × row × col) and issues one cube-transfer command per tile to the wrapper. Computes per-tile source/destination base addresses, clipped edge-tile extents and inter-row/inter-channel gaps, and waits for each `transfer_done` before issuing the next tile. Reports completion of the whole feature map with a single `done` pulse.

## Interface
- `DATA_WIDTH`, 32, word width in bits; address step per word = DATA_WIDTH/8 bytes
- `ADDR_WIDTH`, 32, byte-address width
- `CUBE_WIDTH`, 6, width of every dimension/offset field

- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-low
- `start`  in  1  one-cycle pulse; latches all configuration inputs
- `fm_src_addr`, `fm_dst_addr`  in  ADDR_WIDTH  feature-map source base / packed destination base
- `fm_channel`, `fm_row`, `fm_col`  in  CUBE_WIDTH  feature-map dimensions (words)
- `tile_channel`, `tile_row`, `tile_col`  in  CUBE_WIDTH  nominal tile dimensions
- `src_base_addr`, `dst_base_addr`  out  ADDR_WIDTH  current tile command addresses
- `channel`, `row`, `col`  out  CUBE_WIDTH  current (clipped) tile extents
- `channel_offset`, `row_offset`  out  CUBE_WIDTH  source gaps in words
- `transfer_start`  out  1  one-cycle command pulse to the wrapper
- `transfer_done`  in  1  one-cycle completion pulse from the wrapper
- `busy`  out  1  high from accepted `start` until `done`
- `done`  out  1  one-cycle pulse, all tiles complete
- `config_err`  out  1  sticky until next accepted `start`
- `busy_cycles`  out  32  performance counter (see Configuration)

## Operation
- FSM states: IDLE, CALC, ISSUE, WAIT, NEXT, FIN.
- IDLE: `start`=1 → latch config, zero tile indices (c0,r0,k0) and dst accumulator, clear `config_err`, go CALC. If any fm_* or tile_* dimension is 0 → set `config_err`, go FIN (no transfers).
- CALC: register command outputs for the current tile:
  - `col` = min(tile_col, fm_col−k0); `row` = min(tile_row, fm_row−r0); `channel` = min(tile_channel, fm_channel−c0)
  - `src_base_addr` = fm_src_addr + ((c0·fm_row + r0)·fm_col + k0)·(DATA_WIDTH/8), modulo 2^ADDR_WIDTH
  - `dst_base_addr` = fm_dst_addr + (sum of channel·row·col of all prior tiles)·(DATA_WIDTH/8); destination tiles packed contiguously
  - `row_offset` = fm_col − col; `channel_offset` = (fm_row − row)·fm_col
  - If the full-precision `channel_offset` ≥ 2^CUBE_WIDTH → set `config_err`, go FIN without issuing this or any later tile.
  - Otherwise go ISSUE.
- ISSUE: `transfer_start`=1 for exactly this cycle, go WAIT.
- WAIT: hold all command outputs stable; on `transfer_done`=1 go NEXT.
- NEXT: advance indices, col fastest: k0+=tile_col; on k0≥fm_col → k0=0, r0+=tile_row; on r0≥fm_row → r0=0, c0+=tile_channel; on c0≥fm_channel → FIN; else CALC.
- FIN: `done`=1 for one cycle, go IDLE.
- `start` is ignored outside IDLE.
- `transfer_done` is ignored outside WAIT.
- Internal index and product arithmetic is at least 3·CUBE_WIDTH bits wide; no truncation before the final address add.

## Timing
- Reset (`rst`=0 at a clk edge): state IDLE; all outputs 0, including `busy_cycles`.
- Reset mid-transfer aborts immediately. No `done` pulse. The wrapper is reset by the same `rst`.
- `start` at edge N → CALC at N+1, `transfer_start` high in cycle N+2.
- `transfer_done` at edge M → next `transfer_start` at M+3 (NEXT, CALC, ISSUE).
- Last `transfer_done` at edge M → `done` high in cycle M+2.
- `busy` falls in the same cycle `done` is high.
- Command outputs change only in CALC.
- Error path: `start` with a zero dimension → `done` in cycle N+2, `config_err`=1 from N+1.

## Configuration
- `CUBE_TILE_SCHED_PERF_EN` defined: `busy_cycles` counts clk cycles with `busy`=1. It is cleared on accepted `start`, saturates at 2^32−1, and holds after `done`.
- Not defined: `busy_cycles` tied to 0; no counter logic is compiled in.

## Test plan
- fm 2×4×6, tile 1×2×3, src 0x1000, dst 0x2000; wrapper model replies `transfer_done` 5 cycles after `transfer_start` → exactly 8 commands with src 0x1000, 0x100C, 0x1030, 0x103C, 0x1060, …; dst 0x2000 + i·0x18 (last 0x20A8); row_offset=3, channel_offset=12; one `done`.
- Edge clipping: fm 1×1×7, tile 1×1×3 → col = 3, 3, 1; src 0x1000, 0x100C, 0x1018; dst 0x2000, 0x200C, 0x2018.
- Tile ≥ fm (fm 2×4×6, tile 8×8×8) → single command: channel=2, row=4, col=6, row_offset=0, channel_offset=0.
- `tile_row`=0 → no `transfer_start`, `config_err`=1, `done` two cycles after `start`. Also fm 1×63×63, tile 1×1×63 → `config_err` (offset 3906 does not fit in 6 bits), zero transfers.
- Second `start` during WAIT is ignored; the command count is unchanged. `rst`=0 during WAIT → all outputs 0 next cycle, no `done`; a fresh `start` then completes normally.
- With `CUBE_TILE_SCHED_PERF_EN`: scenario 1 → `busy_cycles` equals the measured start-to-done cycle count. Without the macro → `busy_cycles` stays 0.
